// File: rtl/psrv32_pkg.sv
// Shared PSRV32 core definitions: register address width, x0 and pipeline
// sequencing states.
package psrv32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    REDIRECT  = 2'd2,
    ERROR     = 2'd3
  } pipe_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: the instruction in ID reads a register that the
// load currently in EX has not yet produced.
module hazard_detect
  import psrv32_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  uses_rs1,
  input  logic                  uses_rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  mem_read,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = uses_rs1 & (rs1 == rd);
  assign rs2_hit  = uses_rs2 & (rs2 == rd);
  // x0 is never written, so a load targeting it cannot create a dependency.
  assign load_use = mem_read & (rd != REG_X0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// PSRV32 pipeline sequencing controller: stage enables/flushes for load-use,
// data-memory wait states with timeout, and branch/jump redirects.
module pipeline_ctrl
  import psrv32_pkg::*;
#(
  parameter int IMEM_LAT     = 1,
  parameter int DMEM_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_branch_taken_i,
  input  logic                  ex_jump_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ack_i,
  output logic                  pc_en_o,
  output logic                  if_id_en_o,
  output logic                  id_ex_en_o,
  output logic                  ex_mem_en_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  mem_wb_bubble_o,
  output logic                  err_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam bit          HAS_DROP = (IMEM_LAT > 0);
  localparam logic [2:0]  DROP_LD  = 3'(IMEM_LAT);
  localparam logic [15:0] WAIT_MAX = 16'(DMEM_TIMEOUT);

  pipe_state_t      state;
  logic [15:0]      wait_cnt;
  logic [15:0]      wait_inc;
  logic [2:0]       drop_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic load_use;
  logic dmem_stall;
  logic redirect;
  logic freeze;
  logic take_redirect;
  logic take_lu;
  logic drop_fetch;

  hazard_detect u_hazard (
    .rs1      (id_rs1_i),
    .rs2      (id_rs2_i),
    .uses_rs1 (id_uses_rs1_i),
    .uses_rs2 (id_uses_rs2_i),
    .rd       (ex_rd_i),
    .mem_read (ex_mem_read_i),
    .load_use (load_use)
  );

  assign wait_inc = wait_cnt + 16'd1;

  // Event decode and Mealy stage controls
  always_comb begin
    dmem_stall    = dmem_req_i & ~dmem_ack_i;
    redirect      = ex_branch_taken_i | ex_jump_i;
    freeze        = 1'b0;
    take_redirect = 1'b0;
    take_lu       = 1'b0;
    drop_fetch    = 1'b0;
    case (state)
      RUN:       freeze = dmem_stall;
      DMEM_WAIT: freeze = ~dmem_ack_i;
      REDIRECT:  freeze = dmem_stall;
      default:   freeze = 1'b0;
    endcase
    if (state != ERROR && !freeze) begin
      take_redirect = redirect;
      take_lu       = ~redirect & load_use & (state != REDIRECT);
      drop_fetch    = ~redirect & (state == REDIRECT);
    end

    pc_en_o         = 1'b1;
    if_id_en_o      = 1'b1;
    id_ex_en_o      = 1'b1;
    ex_mem_en_o     = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    mem_wb_bubble_o = 1'b0;
    if (rst_i || state == ERROR) begin
      pc_en_o         = 1'b0;
      if_id_en_o      = 1'b0;
      id_ex_en_o      = 1'b0;
      ex_mem_en_o     = 1'b0;
      if_id_flush_o   = 1'b1;
      id_ex_flush_o   = 1'b1;
      mem_wb_bubble_o = 1'b1;
    end else if (freeze) begin
      pc_en_o         = 1'b0;
      if_id_en_o      = 1'b0;
      id_ex_en_o      = 1'b0;
      ex_mem_en_o     = 1'b0;
      mem_wb_bubble_o = 1'b1;
    end else if (take_redirect) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (take_lu) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end else if (drop_fetch) begin
      if_id_flush_o = 1'b1;
    end
  end

  // Registered state, internal counts and performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      wait_cnt  <= '0;
      drop_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != ERROR && !pc_en_o) stall_cnt <= stall_cnt + CNT_W'(1);
      if (take_redirect) flush_cnt <= flush_cnt + CNT_W'(1);
      case (state)
        RUN: begin
          if (freeze) begin
            state    <= DMEM_WAIT;
            wait_cnt <= 16'd1;
          end else if (take_redirect && HAS_DROP) begin
            state    <= REDIRECT;
            drop_cnt <= DROP_LD;
          end
        end
        DMEM_WAIT: begin
          if (freeze) begin
            wait_cnt <= wait_inc;
            if (wait_inc == WAIT_MAX) state <= ERROR;
          end else begin
            wait_cnt <= '0;
            if (take_redirect && HAS_DROP) begin
              state    <= REDIRECT;
              drop_cnt <= DROP_LD;
            end else begin
              state <= RUN;
            end
          end
        end
        REDIRECT: begin
          // A frozen pipe keeps the stale fetch in flight, so drop_cnt holds.
          if (take_redirect) begin
            drop_cnt <= DROP_LD;
          end else if (drop_fetch) begin
            drop_cnt <= drop_cnt - 3'd1;
            if (drop_cnt == 3'd1) state <= RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign err_o       = ~rst_i & (state == ERROR);
  assign state_o     = rst_i ? RUN : state;
  assign stall_cnt_o = rst_i ? '0 : stall_cnt;
  assign flush_cnt_o = rst_i ? '0 : flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table with hand-derived expectations,
// then randomized traffic against a cycle-level behavioural model.
module tb_pipeline_ctrl;
  import psrv32_pkg::*;

  localparam int LAT = 2;
  localparam int TO  = 4;
  localparam int CW  = 32;

  localparam logic [6:0] C_DEF = 7'b1111000;
  localparam logic [6:0] C_RST = 7'b0000111;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_LU  = 7'b0011010;
  localparam logic [6:0] C_RDR = 7'b1111110;
  localparam logic [6:0] C_DRP = 7'b1111100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, u1, u2, mr, br, jp, req, ack;
  logic [4:0] rs1, rs2, rd;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, bubble, err;
  logic [1:0] st;
  logic [CW-1:0] sc, fc;

  pipeline_ctrl #(.IMEM_LAT(LAT), .DMEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
    .ex_rd_i(rd), .ex_mem_read_i(mr), .ex_branch_taken_i(br), .ex_jump_i(jp),
    .dmem_req_i(req), .dmem_ack_i(ack),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en), .ex_mem_en_o(ex_mem_en),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush), .mem_wb_bubble_o(bubble),
    .err_o(err), .state_o(st), .stall_cnt_o(sc), .flush_cnt_o(fc)
  );

  logic [6:0] ctl;
  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, bubble};

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: mode 0 run, 1 waiting on dmem, 2 discarding fetches, 3 error
  int m_mode, m_drop, m_wait;
  logic [CW-1:0] m_sc, m_fc;
  logic [6:0] e_ctl;
  logic [1:0] e_st;
  logic e_err;
  logic [CW-1:0] e_sc, e_fc;

  function automatic void model_step();
    logic frozen, redir, lu;
    if (rst) begin
      e_ctl = C_RST; e_st = 2'd0; e_err = 1'b0; e_sc = '0; e_fc = '0;
      m_mode = 0; m_drop = 0; m_wait = 0; m_sc = '0; m_fc = '0;
      return;
    end
    e_st = 2'(m_mode); e_sc = m_sc; e_fc = m_fc; e_err = (m_mode == 3);
    if (m_mode == 3) begin
      e_ctl = C_RST;
      return;
    end
    frozen = (m_mode == 1) ? !ack : (req && !ack);
    redir  = br || jp;
    lu     = mr && rd != 5'd0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (frozen) begin
      e_ctl = C_FRZ; m_sc++;
      if (m_mode == 0) begin m_mode = 1; m_wait = 1; end
      else if (m_mode == 1) begin m_wait++; if (m_wait == TO) m_mode = 3; end
    end else if (redir) begin
      e_ctl = C_RDR; m_fc++;
      if (LAT > 0) begin m_mode = 2; m_drop = LAT; end else m_mode = 0;
    end else if (lu && m_mode != 2) begin
      e_ctl = C_LU; m_sc++; m_mode = 0;
    end else if (m_mode == 2) begin
      e_ctl = C_DRP; m_drop--;
      if (m_drop == 0) m_mode = 0;
    end else begin
      e_ctl = C_DEF; m_mode = 0;
    end
  endfunction

  typedef struct {
    logic r; int lu; logic b, j, q, a;
    logic [6:0] c; logic [1:0] s; logic e; int scx, fcx;
  } vec_t;
  vec_t tbl[$];

  // lu: 0 none, 1 rs1 hazard, 2 hazard on x0, 3 rs2 hazard, 4 rs2 match but unused
  task automatic add(input logic r, input int lu, input logic b, j, q, a,
                     input logic [6:0] c, input logic [1:0] s, input logic e, input int scx, fcx);
    vec_t v;
    v.r = r; v.lu = lu; v.b = b; v.j = j; v.q = q; v.a = a;
    v.c = c; v.s = s; v.e = e; v.scx = scx; v.fcx = fcx;
    tbl.push_back(v);
  endtask

  task automatic set_lu(input int lu);
    rs1 = 5'd1; rs2 = 5'd2; u1 = 1'b0; u2 = 1'b0; rd = 5'd3; mr = 1'b0;
    case (lu)
      1: begin mr = 1'b1; rd = 5'd5; rs1 = 5'd5; u1 = 1'b1; end
      2: begin mr = 1'b1; rd = 5'd0; rs1 = 5'd0; u1 = 1'b1; end
      3: begin mr = 1'b1; rd = 5'd7; rs2 = 5'd7; u2 = 1'b1; end
      4: begin mr = 1'b1; rd = 5'd7; rs2 = 5'd7; u2 = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic model_checks(input string tag);
    check({tag, "_ctl"}, 64'(ctl), 64'(e_ctl));
    check({tag, "_state"}, 64'(st), 64'(e_st));
    check({tag, "_err"}, 64'(err), 64'(e_err));
    check({tag, "_stall_cnt"}, 64'(sc), 64'(e_sc));
    check({tag, "_flush_cnt"}, 64'(fc), 64'(e_fc));
  endtask

  initial begin
    rst = 1'b1; br = 1'b0; jp = 1'b0; req = 1'b0; ack = 1'b0;
    set_lu(0);
    m_mode = 0; m_drop = 0; m_wait = 0; m_sc = '0; m_fc = '0;

    //   r lu b  j  q  a  ctl    st err sc fc
    add(1, 0, 0, 0, 0, 0, C_RST, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, C_LU,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 1, 0);
    add(0, 2, 0, 0, 0, 0, C_DEF, 0, 0, 1, 0);
    add(0, 3, 0, 0, 0, 0, C_LU,  0, 0, 1, 0);
    add(0, 4, 0, 0, 0, 0, C_DEF, 0, 0, 2, 0);
    add(0, 0, 0, 0, 1, 1, C_DEF, 0, 0, 2, 0);
    add(0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 2, 0);
    add(0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 3, 0);
    add(0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 4, 0);
    add(0, 0, 0, 0, 1, 1, C_DEF, 1, 0, 5, 0);
    add(0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 5, 0);
    add(0, 0, 1, 0, 0, 0, C_RDR, 0, 0, 5, 0);
    add(0, 0, 0, 0, 0, 0, C_DRP, 2, 0, 5, 1);
    add(0, 0, 0, 0, 0, 0, C_DRP, 2, 0, 5, 1);
    add(0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 5, 1);
    add(0, 0, 1, 0, 1, 0, C_FRZ, 0, 0, 5, 1);
    add(0, 0, 1, 0, 1, 0, C_FRZ, 1, 0, 6, 1);
    add(0, 0, 1, 0, 1, 1, C_RDR, 1, 0, 7, 1);
    add(0, 0, 0, 0, 0, 0, C_DRP, 2, 0, 7, 2);
    add(0, 0, 0, 1, 0, 0, C_RDR, 2, 0, 7, 2);
    add(0, 0, 0, 0, 0, 0, C_DRP, 2, 0, 7, 3);
    add(0, 0, 0, 0, 0, 0, C_DRP, 2, 0, 7, 3);
    add(0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 7, 3);
    add(0, 0, 1, 0, 0, 0, C_RDR, 0, 0, 7, 3);
    add(0, 0, 0, 0, 1, 0, C_FRZ, 2, 0, 7, 4);
    add(0, 1, 0, 0, 0, 0, C_DRP, 2, 0, 8, 4);
    add(0, 0, 0, 0, 0, 0, C_DRP, 2, 0, 8, 4);
    add(0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 8, 4);
    add(0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 8, 4);
    add(0, 1, 0, 0, 1, 1, C_LU,  1, 0, 9, 4);
    add(0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 10, 4);
    add(0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 10, 4);
    add(0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 11, 4);
    add(0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 12, 4);
    add(0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 13, 4);
    add(0, 0, 0, 0, 1, 0, C_RST, 3, 1, 14, 4);
    add(0, 0, 0, 0, 0, 0, C_RST, 3, 1, 14, 4);
    add(1, 0, 0, 0, 0, 0, C_RST, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, C_RDR, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, C_RST, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, C_RST, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, C_DEF, 0, 0, 0, 0);

    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      rst = tbl[i].r; br = tbl[i].b; jp = tbl[i].j; req = tbl[i].q; ack = tbl[i].a;
      set_lu(tbl[i].lu);
      #2;
      model_step();
      check($sformatf("vec%0d_ctl", i), 64'(ctl), 64'(tbl[i].c));
      check($sformatf("vec%0d_state", i), 64'(st), 64'(tbl[i].s));
      check($sformatf("vec%0d_err", i), 64'(err), 64'(tbl[i].e));
      check($sformatf("vec%0d_stall_cnt", i), 64'(sc), 64'(tbl[i].scx));
      check($sformatf("vec%0d_flush_cnt", i), 64'(fc), 64'(tbl[i].fcx));
      check($sformatf("vec%0d_model_ctl", i), 64'(ctl), 64'(e_ctl));
      @(negedge clk);
    end

    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(63) == 0);
      br  = ($urandom_range(7) == 0);
      jp  = ($urandom_range(15) == 0);
      req = ($urandom_range(2) == 0);
      ack = ($urandom_range(1) == 0);
      mr  = ($urandom_range(1) == 0);
      u1  = ($urandom_range(1) == 0);
      u2  = ($urandom_range(1) == 0);
      rs1 = 5'($urandom_range(3));
      rs2 = 5'($urandom_range(3));
      rd  = 5'($urandom_range(3));
      #2;
      model_step();
      model_checks($sformatf("rnd%0d", k));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
